reset_release_sequencer: RTL
============================

Name: reset_release_sequencer

Overview:
Sequences the release of several downstream active-low synchronous resets, one stage at a time. Each stage is held in reset for a fixed number of cycles, then released. The sequencer then waits for that stage's ready acknowledge, with a timeout, before moving to the next stage. It sits above the datapath registers that use `rst_n`, and provides a software-triggered re-reset path and an error report.

Parameters:
- NUM_STAGES, 4: number of downstream reset domains; must be >= 2.
- HOLD_CYCLES, 8: cycles a stage stays in reset before release; must be >= 1.
- TIMEOUT_CYCLES, 255: cycles allowed for a stage's ready after its release; must be >= 1.
- CNT_W, 8: cycle counter width; must hold max(HOLD_CYCLES, TIMEOUT_CYCLES)-1.

Ports:
- clk  in  1  sole clock, all logic on posedge.
- rst  in  1  reset, synchronous, active-high; resets the sequencer itself.
- sw_rst_req  in  1  sampled level; restarts the full sequence.
- stage_ready  in  NUM_STAGES  per-stage acknowledge, sampled only for the stage being awaited.
- stage_rst_n  out  NUM_STAGES  active-low resets to the downstream stages; 0 = held in reset.
- busy  out  1  high while sequencing (ASSERT_ALL, HOLD, WAIT_ACK).
- seq_done  out  1  all stages released and acknowledged.
- seq_error  out  1  ready timeout occurred.
- err_stage  out  max(1,$clog2(NUM_STAGES))  index of the stage that timed out.

Behaviour:
- All outputs are registered. Priority: rst > sw_rst_req > FSM.
- rst=1 at an edge sets:
  - state=ASSERT_ALL, idx=0, cnt=0
  - stage_rst_n=all 0, busy=1, seq_done=0, seq_error=0, err_stage=0
- Edge numbering: edge 1 is the first edge with rst=0.
- ASSERT_ALL / HOLD (hold current stage idx in reset):
  - cnt increments each edge.
  - At the edge where cnt==HOLD_CYCLES-1: set stage_rst_n[idx]=1, cnt=0, go to WAIT_ACK.
  - With defaults, stage_rst_n[0] rises after edge 8.
- WAIT_ACK, evaluated at each edge:
  - If stage_ready[idx]=1 and idx==NUM_STAGES-1: go to DONE; seq_done=1, busy=0.
  - If stage_ready[idx]=1 and idx is not the last stage: idx++, cnt=0, go to HOLD.
  - Otherwise, if cnt==TIMEOUT_CYCLES-1: go to ERROR; seq_error=1, err_stage=idx, busy=0, stage_rst_n[idx]=0.
  - Otherwise cnt++.
  - An ack on the same edge as the timeout wins; no error is raised.
  - Ack is sampled no earlier than the first edge after release.
- DONE: terminal. stage_ready is ignored, including a later deassertion.
- ERROR: terminal. Stages below err_stage stay released; the failed stage and all later stages stay held.
- Gating of stage_ready: bits other than stage_ready[idx] are ignored, including early-high bits. Only stage_ready[idx] in WAIT_ACK has effect.
- sw_rst_req=1 at an edge, in any state including mid-HOLD or mid-WAIT:
  - stage_rst_n=all 0, idx=0, cnt=0
  - seq_done=0, seq_error=0, err_stage=0, busy=1
  - state=ASSERT_ALL, so the timing is identical to a rst release.
  - Held high, it keeps the sequence restarting every edge.
- Reset mid-operation: the same effect as reset at power-up, with no partial-state retention.
- Invariant: stage_rst_n is thermometer-coded at all times (released stages form a contiguous low-index run).

Decomposition:
- Shared package reset_seq_pkg:
  - state encoding constants ST_ASSERT_ALL, ST_HOLD, ST_WAIT_ACK, ST_DONE, ST_ERROR (3-bit)
  - default HOLD/TIMEOUT constants
- One sub-module, rst_seq_counter: CNT_W-bit counter with clear, enable, and a terminal-count compare against a runtime limit. The FSM reuses it for both hold and timeout.

Test Plan:
1. Defaults, stage_ready tied to 4'b1111, rst released → stage_rst_n: 0000 until edge 8, 0001 after edge 8, 0011 after 17, 0111 after 26, 1111 after 35; seq_done=1 and busy=0 after edge 36.
2. TIMEOUT_CYCLES=16, stage_ready[2] held 0 → stage2 released after edge 26; after edge 42: seq_error=1, err_stage=2, stage_rst_n=0011, busy=0, state remains ERROR.
3. In DONE, 1-cycle sw_rst_req → next edge: stage_rst_n=0000, seq_done=0, busy=1; the release sequence repeats with test 1's relative timing. The same pulse in ERROR clears seq_error and err_stage.
4. rst asserted during the HOLD for stage 2 (stage_rst_n=0011) → next edge: all outputs at reset values. rst and sw_rst_req asserted together give identical rst behaviour.
5. TIMEOUT_CYCLES=16, stage_ready[1] rises exactly on the 16th edge after stage1's release → no error; HOLD for stage 2 begins.
6. stage_ready=4'b1000 from reset, stage0 ready 5 cycles after release → stage_ready[3] is ignored; stage 1 is released 8 edges after stage 0's ack edge.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: state encoding and default timing constants for the reset release sequencer.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        ST_ASSERT_ALL = 3'd0,
        ST_HOLD       = 3'd1,
        ST_WAIT_ACK   = 3'd2,
        ST_DONE       = 3'd3,
        ST_ERROR      = 3'd4
    } state_t;

    localparam int DEF_HOLD_CYCLES    = 8;
    localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/rst_seq_counter.sv
// rst_seq_counter: cycle counter with clear/enable and terminal-count compare against a runtime limit.
module rst_seq_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk)
        if (rst || clr) cnt <= '0;
        else if (en)    cnt <= cnt + 1'b1;

    assign tc = cnt == limit;

endmodule

// File: rtl/reset_release_sequencer.sv
// reset_release_sequencer: releases downstream active-low resets one stage at a time,
// holding each for a fixed time and waiting (with timeout) for its ready acknowledge.
module reset_release_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES     = 4,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = 8,
    localparam int IW            = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sw_rst_req,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  busy,
    output logic                  seq_done,
    output logic                  seq_error,
    output logic [IW-1:0]         err_stage
);

    state_t        state;
    logic [IW-1:0] idx;
    logic          tc;

    wire hold_st = state == ST_ASSERT_ALL || state == ST_HOLD;
    wire wait_st = state == ST_WAIT_ACK;
    wire ack     = stage_ready[idx];
    wire last    = idx == IW'(NUM_STAGES - 1);

    // One counter serves both the hold interval and the ack timeout.
    rst_seq_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (sw_rst_req || ((hold_st || wait_st) && tc) || (wait_st && ack)),
        .en    (hold_st || wait_st),
        .limit (wait_st ? CNT_W'(TIMEOUT_CYCLES - 1) : CNT_W'(HOLD_CYCLES - 1)),
        .tc    (tc)
    );

    always_ff @(posedge clk) begin
        if (rst || sw_rst_req) begin
            state       <= ST_ASSERT_ALL;
            idx         <= '0;
            stage_rst_n <= '0;
            busy        <= 1'b1;
            seq_done    <= 1'b0;
            seq_error   <= 1'b0;
            err_stage   <= '0;
        end else begin
            case (state)
                ST_ASSERT_ALL, ST_HOLD:
                    if (tc) begin
                        stage_rst_n[idx] <= 1'b1;
                        state            <= ST_WAIT_ACK;
                    end
                ST_WAIT_ACK:
                    // An ack on the timeout edge takes precedence over the error.
                    if (ack && last) begin
                        state    <= ST_DONE;
                        seq_done <= 1'b1;
                        busy     <= 1'b0;
                    end else if (ack) begin
                        idx   <= idx + 1'b1;
                        state <= ST_HOLD;
                    end else if (tc) begin
                        state            <= ST_ERROR;
                        seq_error        <= 1'b1;
                        err_stage        <= idx;
                        busy             <= 1'b0;
                        stage_rst_n[idx] <= 1'b0;
                    end
                default: ;
            endcase
        end
    end

endmodule
